axi_mem_sram_sched: RTL



---
 rtl/axi_mem_sram_sched_if.sv | 34 +++
 rtl/axi_mem_sram_sched.sv | 92 +++++++++
 2 files changed

// File: rtl/axi_mem_sram_sched_if.sv
// Bundle of the request, response and SRAM signals around the scheduler.
// The slave modport is the scheduler itself; the master modport is its
// environment (the command/response agent together with the SRAM array).
interface axi_mem_sram_sched_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  sram_cs;
    logic                  sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [DATA_WIDTH-1:0] sram_rdata;
    logic                  idle;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_rdata,
        output req_ready, rsp_valid, rsp_rdata, sram_cs, sram_we, sram_addr,
               sram_wdata, idle
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, sram_cs, sram_we, sram_addr,
               sram_wdata, idle
    );
endinterface

// File: rtl/axi_mem_sram_sched.sv
// In-order command scheduler in front of a single-port SRAM with a fixed
// one-cycle read latency. Commands are issued to the SRAM in the cycle they
// are accepted; read data is captured into a small response FIFO. Acceptance
// is credit-gated so every in-flight read already owns a FIFO slot, which
// means response backpressure can never drop data.
module axi_mem_sram_sched #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_mem_sram_sched_if.slave    bus
);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic                  rd_pend;

    logic                  pop;
    logic                  push;
    logic                  accept;
    logic [OCC_W-1:0]      occ;

    // Pointer advance with wrap at RSP_DEPTH (depth need not be a power of 2).
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Occupancy counts both stored responses and the read whose data is
    // arriving this cycle; a pop this cycle frees a slot immediately, which
    // is what lets back-to-back reads stream with a two-entry FIFO.
    assign pop    = bus.rsp_valid & bus.rsp_ready;
    assign push   = rd_pend;
    assign occ    = {1'b0, fifo_count} + OCC_W'(rd_pend);
    assign accept = bus.req_valid & bus.req_ready;

    assign bus.req_ready  = !rst && ((occ - OCC_W'(pop)) < OCC_W'(RSP_DEPTH));

    // Issue goes straight to the SRAM; address and data are passed through
    // unconditionally and only the chip select is qualified.
    assign bus.sram_cs    = accept;
    assign bus.sram_we    = bus.req_we;
    assign bus.sram_addr  = bus.req_addr;
    assign bus.sram_wdata = bus.req_wdata;

    // No bypass path: responses are only presented from the FIFO head.
    assign bus.rsp_valid  = (fifo_count != '0);
    assign bus.rsp_rdata  = fifo_mem[rd_ptr];
    assign bus.idle       = !rd_pend && (fifo_count == '0);

    // Control state: read-in-flight flag, FIFO pointers and entry count.
    // Reset clears them, so SRAM data landing in the reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            rd_pend <= accept & !bus.req_we;
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Response storage: capture SRAM read data one cycle after the read issue.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.sram_rdata;
        end
    end

    // Credit gating guarantees a free slot (or a simultaneous pop) for every push.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        push |-> ((fifo_count < CNT_W'(RSP_DEPTH)) || pop));

endmodule
